counter_modsat: RTL
===================

Name: counter_modsat

Overview:
- Parametrised successor to the team's basic up/down loadable counter.
- Adds a programmable modulus (terminal value), a per-cycle step size, selectable wrap or saturate mode, sticky overflow/underflow flags and a wrap strobe.
- Used as a general event/timebase counter in datapath and test harnesses.
- Keeps the original control set (load_n, ce, up_down, data_load) so existing stimulus and checks carry over.

Parameters:
- WIDTH, 4, bit width of count_out, data_load and step.
- MAX_VAL, 2**WIDTH-1, terminal count; legal range 1..2**WIDTH-1; the count lives in 0..MAX_VAL.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; asynchronous assert, active-low.
- load_n  in  1  active-low synchronous load.
- ce  in  1  count enable.
- up_down  in  1  1 = count up, 0 = count down.
- sat_en  in  1  1 = saturate at the bounds, 0 = wrap modulo MAX_VAL+1.
- step  in  WIDTH  increment/decrement amount per enabled cycle.
- data_load  in  WIDTH  value loaded when load_n = 0.
- clr_flags  in  1  synchronous clear of ovf and unf.
- count_out  out  WIDTH  registered count.
- max_count  out  1  combinational: count_out == MAX_VAL.
- zero  out  1  combinational: count_out == 0.
- ovf  out  1  sticky: an up-count exceeded MAX_VAL.
- unf  out  1  sticky: a down-count went below 0.
- wrap_pulse  out  1  registered one-cycle strobe; high the cycle after a wrap.

Behaviour:
- Reset (rst_n = 0, asynchronous): count_out = 0, ovf = 0, unf = 0, wrap_pulse = 0. Consequently zero = 1 and max_count = 0 (max_count = 1 only if MAX_VAL = 0, which is illegal).
- Priority per rising edge: rst_n, then load, then count.
- Load (load_n = 0):
  - count_out <= min(data_load, MAX_VAL).
  - ce, step and up_down are ignored.
  - Flags hold; wrap_pulse <= 0.
- Hold (load_n = 1, ce = 0, or step_eff = 0): count_out holds; wrap_pulse <= 0.
- Step clamping: step_eff = min(step, MAX_VAL).
- Up count (ce = 1, up_down = 1): sum = count_out + step_eff, computed WIDTH+1 bits wide.
  - sum <= MAX_VAL: count_out <= sum.
  - sum > MAX_VAL, sat_en = 1: count_out <= MAX_VAL; ovf <= 1; wrap_pulse <= 0.
  - sum > MAX_VAL, sat_en = 0: count_out <= sum - (MAX_VAL+1); ovf <= 1; wrap_pulse <= 1.
- Down count (ce = 1, up_down = 0):
  - step_eff <= count_out: count_out <= count_out - step_eff.
  - Otherwise, sat_en = 1: count_out <= 0; unf <= 1.
  - Otherwise, sat_en = 0: count_out <= count_out + (MAX_VAL+1) - step_eff, computed WIDTH+1 bits wide; unf <= 1; wrap_pulse <= 1.
- Landing exactly on MAX_VAL (up) or on 0 (down) is not an overflow or underflow.
- Saturated and already at the bound with a further step: count_out holds and the flag is (re)set.
- Sticky flags:
  - clr_flags = 1 clears ovf and unf next edge.
  - If a set event and clr_flags occur in the same cycle, the set wins (flag = 1).
  - clr_flags during a load is still honoured.
- wrap_pulse is exactly one cycle per wrapping step. Back-to-back wraps keep it high on consecutive cycles.
- Mode changes: sat_en and up_down may change every cycle; each edge uses the current-cycle values only.
- Reset mid-count: outputs go to reset values immediately, independent of clk. The first edge after rst_n deasserts behaves normally.
- Latency: count_out, ovf, unf and wrap_pulse update 1 cycle after the controlling inputs. max_count and zero follow count_out with 0 cycles.

Test Plan:
- WIDTH=4, MAX_VAL=9; reset, then load_n=0, data_load=13 -> count_out=9, max_count=1, flags 0.
- count_out=8, ce=1, up, step=3, sat_en=0 -> count_out=1, ovf=1, wrap_pulse=1 for exactly one cycle; the next up step of 3 gives count_out=4 with wrap_pulse=0.
- count_out=2, down, step=5, sat_en=1 -> count_out=0, zero=1, unf=1, wrap_pulse=0. Repeat -> count_out stays 0, unf stays 1.
- count_out=2, down, step=5, sat_en=0 -> count_out=7, unf=1, wrap_pulse=1.
- ovf=1 and a wrap event coincide with clr_flags=1 -> ovf stays 1. Next cycle, clr_flags=1 with no event -> ovf=0.
- rst_n pulsed low mid-cycle while count_out=6 and ovf=1 -> count_out=0 and ovf=0 before the next clk edge. load_n=0 with ce=1 -> data_load wins.

Source files
------------

// File: rtl/counter_modsat.sv
// Up/down loadable counter with programmable modulus, step size,
// wrap-or-saturate mode, sticky overflow/underflow flags and a wrap strobe.
module counter_modsat #(
  parameter int WIDTH   = 4,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_n,
  input  logic             ce,
  input  logic             up_down,
  input  logic             sat_en,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] data_load,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count_out,
  output logic             max_count,
  output logic             zero,
  output logic             ovf,
  output logic             unf,
  output logic             wrap_pulse
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam logic [WIDTH:0]   MODV = (WIDTH+1)'(MAX_VAL + 1);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] step_eff;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH:0]   sum_up;
  logic             over;
  logic             under;
  logic             do_up;
  logic             do_dn;
  logic             ovf_set;
  logic             unf_set;
  logic             wrap_d;
  logic             ovf_q;
  logic             unf_q;
  logic             wrap_q;

  assign step_eff = (step > MAXV) ? MAXV : step;
  assign load_val = (data_load > MAXV) ? MAXV : data_load;
  assign sum_up   = {1'b0, cnt_q} + {1'b0, step_eff};
  assign over     = sum_up > {1'b0, MAXV};
  assign under    = step_eff > cnt_q;
  assign do_up    = load_n & ce & up_down;
  assign do_dn    = load_n & ce & ~up_down;

  always_comb begin
    cnt_d   = cnt_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    wrap_d  = 1'b0;
    unique case (1'b1)
      !load_n: cnt_d = load_val;
      do_up: begin
        if (!over) begin
          cnt_d = sum_up[WIDTH-1:0];
        end else if (sat_en) begin
          cnt_d   = MAXV;
          ovf_set = 1'b1;
        end else begin
          cnt_d   = WIDTH'(sum_up - MODV);
          ovf_set = 1'b1;
          wrap_d  = 1'b1;
        end
      end
      do_dn: begin
        if (!under) begin
          cnt_d = cnt_q - step_eff;
        end else if (sat_en) begin
          cnt_d   = '0;
          unf_set = 1'b1;
        end else begin
          // borrow from the modulus; result is always below MODV
          cnt_d   = WIDTH'({1'b0, cnt_q} + MODV - {1'b0, step_eff});
          unf_set = 1'b1;
          wrap_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_set | (ovf_q & ~clr_flags);
      unf_q  <= unf_set | (unf_q & ~clr_flags);
      wrap_q <= wrap_d;
    end
  end

  assign count_out  = cnt_q;
  assign max_count  = (cnt_q == MAXV);
  assign zero       = (cnt_q == '0);
  assign ovf        = ovf_q;
  assign unf        = unf_q;
  assign wrap_pulse = wrap_q;

endmodule
